// File: rtl/ifetch.sv
// ifetch: FETCH/ISSUE sequencer. Ack to instr_valid is 1 cycle, so peak rate is one instr per 2 cycles. stall holds ISSUE with all outputs stable.
// Define IFETCH_TIMEOUT_EN to add a fetch timeout counter and a sticky ERROR state, left only by reset.
module ifetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

`ifdef IFETCH_TIMEOUT_EN
  typedef enum logic [1:0] {FETCH = 2'd0, ISSUE = 2'd1, ERROR = 2'd2} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] toCnt;
  logic          fetchErr;
`else
  typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instrQ;
  logic        reqQ;
  logic        validQ;
  logic [31:0] pcNext4;
  logic [31:0] branchOff;

  assign pcNext4   = pc + 32'd4;
  assign branchOff = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      instrQ   <= '0;
      reqQ     <= 1'b1;
      validQ   <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      toCnt    <= '0;
      fetchErr <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instrQ <= imem_rdata;
            state  <= ISSUE;
            reqQ   <= 1'b0;
            validQ <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
            toCnt  <= '0;
          end else if (toCnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state    <= ERROR;
            reqQ     <= 1'b0;
            fetchErr <= 1'b1;
          end else begin
            toCnt <= toCnt + CW'(1);
`endif
          end
        end
        ISSUE: begin
          // Branch inputs only matter on the cycle the instruction is consumed.
          if (!stall) begin
            pc     <= branch_taken ? pcNext4 + branchOff : pcNext4;
            state  <= FETCH;
            reqQ   <= 1'b1;
            validQ <= 1'b0;
          end
        end
        default: begin
          reqQ   <= 1'b0;
          validQ <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = reqQ;
  assign imem_addr   = pc;
  assign instr       = instrQ;
  assign op          = instrQ[31:26];
  assign instr_valid = validQ;
  assign pc_plus4    = pcNext4;
`ifdef IFETCH_TIMEOUT_EN
  assign fetch_err   = fetchErr;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a per-cycle vector table plus hand-written sequences for stall, wrap, async reset and timeout.
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall, branch_taken;
  logic [15:0] branch_imm;
  logic [31:0] instr, instr2;
  logic [5:0]  op, op2;
  logic        instr_valid, instr_valid2;
  logic [31:0] pc_plus4, pc_plus42;
  logic        fetch_err, fetch_err2;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_imm(branch_imm), .instr(instr),
    .op(op), .instr_valid(instr_valid), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_imm(branch_imm), .instr(instr2),
    .op(op2), .instr_valid(instr_valid2), .pc_plus4(pc_plus42), .fetch_err(fetch_err2)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        stl;
    logic        bt;
    logic [15:0] imm;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic [31:0] d, input logic s,
                       input logic b, input logic [15:0] i);
    imem_ack = a; imem_rdata = d; stall = s; branch_taken = b; branch_imm = i;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 16'h0000, 1'b1, 32'h000, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h8C01_0004, 1'b0, 1'b1, 16'h0007, 1'b1, 32'h000, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 16'h0040, 1'b0, 32'h000, 1'b1, 32'h8C01_0004};
    vecs[3]  = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h000, 1'b1, 32'h8C01_0004};
    vecs[4]  = '{1'b1, 32'h1000_003E, 1'b0, 1'b1, 16'h7777, 1'b1, 32'h004, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 16'h003E, 1'b0, 32'h004, 1'b1, 32'h1000_003E};
    vecs[6]  = '{1'b1, 32'h1000_FFFE, 1'b0, 1'b0, 16'h0000, 1'b1, 32'h100, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 16'hFFFE, 1'b0, 32'h100, 1'b1, 32'h1000_FFFE};
    vecs[8]  = '{1'b1, 32'h8C01_0004, 1'b0, 1'b0, 16'h0000, 1'b1, 32'h0FC, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0FC, 1'b1, 32'h8C01_0004};
    vecs[10] = '{1'b1, 32'h1000_0003, 1'b0, 1'b0, 16'h0000, 1'b1, 32'h100, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 16'h0003, 1'b0, 32'h100, 1'b1, 32'h1000_0003};
    vecs[12] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 16'h0000, 1'b1, 32'h110, 1'b0, 32'h0};

    // Reset state, sampled while rst_n is still low.
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("rst req", 32'(imem_req), 32'd1);
    chk("rst addr", imem_addr, 32'h0);
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst instr", instr, 32'h0);
    chk("rst err", 32'(fetch_err), 32'd0);
    chk("rst wrap addr", imem_addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: check the current outputs, then apply this cycle's inputs.
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("vec%0d req", i), 32'(imem_req), 32'(vecs[i].expReq));
      chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].expAddr);
      chk($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].expValid));
      chk($sformatf("vec%0d pc_plus4", i), pc_plus4, vecs[i].expAddr + 32'd4);
      if (vecs[i].expValid) begin
        chk($sformatf("vec%0d instr", i), instr, vecs[i].expInstr);
        chk($sformatf("vec%0d op", i), 32'(op), 32'(vecs[i].expInstr[31:26]));
      end
      drive(vecs[i].ack, vecs[i].rdata, vecs[i].stl, vecs[i].bt, vecs[i].imm);
      @(negedge clk);
    end

    // Ack tied high from the first request cycle: addresses 0,4,8 at one instr per 2 cycles.
    doReset();
    drive(1'b1, 32'h8C01_0004, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        chk($sformatf("stream%0d req", k), 32'(imem_req), 32'd1);
        chk($sformatf("stream%0d addr", k), imem_addr, 32'(4 * (k / 2)));
        chk($sformatf("stream%0d wrap addr", k), imem_addr2, 32'hFFFF_FFFC + 32'(4 * (k / 2)));
      end else begin
        chk($sformatf("stream%0d valid", k), 32'(instr_valid), 32'd1);
        chk($sformatf("stream%0d op", k), 32'(op), 32'(6'b100011));
      end
      @(negedge clk);
    end

    // Five stalled ISSUE cycles: nothing moves, then exactly one PC advance.
    doReset();
    drive(1'b1, 32'hAC02_0008, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d valid", k), 32'(instr_valid), 32'd1);
      chk($sformatf("stall%0d req", k), 32'(imem_req), 32'd0);
      chk($sformatf("stall%0d instr", k), instr, 32'hAC02_0008);
      chk($sformatf("stall%0d pc_plus4", k), pc_plus4, 32'h4);
      drive(1'b1, 32'h5555_0000 + 32'(k), 1'b1, 1'b1, 16'h0100);
      @(negedge clk);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("unstall addr", imem_addr, 32'h4);
    chk("unstall req", 32'(imem_req), 32'd1);
    chk("unstall valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("unstall hold addr", imem_addr, 32'h4);

    // Asynchronous reset in the middle of an ISSUE cycle.
    drive(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    chk("pre-arst valid", 32'(instr_valid), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(instr_valid), 32'd0);
    chk("arst req", 32'(imem_req), 32'd1);
    chk("arst addr", imem_addr, 32'h0);
    chk("arst instr", instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("post-arst req", 32'(imem_req), 32'd1);
    chk("post-arst addr", imem_addr, 32'h0);

`ifdef IFETCH_TIMEOUT_EN
    // 16 un-acked FETCH cycles trip the sticky error.
    doReset();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("to%0d err", k), 32'(fetch_err), 32'd0);
      @(negedge clk);
    end
    chk("timeout err", 32'(fetch_err), 32'd1);
    chk("timeout req", 32'(imem_req), 32'd0);
    drive(1'b1, 32'h8C01_0004, 1'b0, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    chk("timeout sticky err", 32'(fetch_err), 32'd1);
    chk("timeout sticky req", 32'(imem_req), 32'd0);
    chk("timeout sticky valid", 32'(instr_valid), 32'd0);
    // An ack on the last allowed cycle is accepted without error.
    doReset();
    repeat (15) @(negedge clk);
    drive(1'b1, 32'h8C01_0004, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("late ack err", 32'(fetch_err), 32'd0);
    chk("late ack valid", 32'(instr_valid), 32'd1);
`else
    // Without the timeout, FETCH waits indefinitely.
    doReset();
    repeat (20) @(negedge clk);
    chk("no-timeout err", 32'(fetch_err), 32'd0);
    chk("no-timeout req", 32'(imem_req), 32'd1);
    chk("no-timeout addr", imem_addr, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum number of FETCH cycles without imem_ack (used only when the timeout feature is compiled in).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_req, output, 1, instruction memory read request.
REQ-006 SHALL have port imem_addr, output, 32, byte address of the request; always equals pc.
REQ-007 SHALL have port imem_ack, input, 1, memory indicates that imem_rdata is valid this cycle.
REQ-008 SHALL have port imem_rdata, input, 32, instruction word.
REQ-009 SHALL have port stall, input, 1, downstream decode/execute not ready to consume.
REQ-010 SHALL have port branch_taken, input, 1, Branch AND Zero from the datapath for the issued instruction.
REQ-011 SHALL have port branch_imm, input, 16, the issued instruction's immediate field.
REQ-012 SHALL have port instr, output, 32, registered issued instruction.
REQ-013 SHALL have port op, output, 6, instr[31:26], feeding the main control decoder.
REQ-014 SHALL have port instr_valid, output, 1, instr holds a valid instruction.
REQ-015 SHALL have port pc_plus4, output, 32, pc+4 of the issued instruction.
REQ-016 SHALL have port fetch_err, output, 1, sticky fetch timeout flag.

Function
REQ-017 SHALL implement states FETCH, ISSUE and ERROR; ERROR exists only with IFETCH_TIMEOUT_EN.
REQ-018 FETCH: imem_req=1, instr_valid=0; on imem_ack=1, instr<=imem_rdata, next state ISSUE; otherwise remain in FETCH.
REQ-019 An ack in the same cycle as the first req cycle SHALL be accepted: instr_valid=1 on the following cycle (1-cycle latency).
REQ-020 ISSUE: imem_req=0, instr_valid=1; instr, op, pc_plus4 SHALL remain stable while stall=1.
REQ-021 ISSUE with stall=0: pc<=branch_taken ? pc+4+(sign_extend(branch_imm)<<2) : pc+4; next state FETCH.
REQ-022 branch_taken and branch_imm SHALL be sampled only in the ISSUE cycle with stall=0 and ignored in all other cycles.
REQ-023 imem_ack SHALL be ignored outside FETCH.
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0; backward targets wrap identically.
REQ-025 pc[1:0] SHALL always be 0 given an aligned RESET_PC.
REQ-026 Peak throughput SHALL be one instruction per 2 cycles.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0 and clear the timeout counter.
REQ-028 A reset asserted mid-FETCH or mid-ISSUE SHALL abandon the pending transaction; imem_req=1 in the first cycle after release, with imem_addr=RESET_PC.

Configuration
REQ-029 With IFETCH_TIMEOUT_EN defined: the counter increments on each FETCH cycle without ack and clears on ack; after TIMEOUT_CYCLES consecutive un-acked cycles, enter ERROR: imem_req=0, instr_valid=0, fetch_err=1, exit only by reset.
REQ-030 Without IFETCH_TIMEOUT_EN: no counter or ERROR state, fetch_err tied to 0, FETCH waits indefinitely.

Verification
REQ-031 Reset release, imem_ack tied to 1, imem_rdata=32'h8C01_0004, stall=0 -> imem_addr sequence 0,4,8; op=6'b100011 whenever instr_valid=1.
REQ-032 In ISSUE at pc=0x100, branch_taken=1, branch_imm=16'hFFFE -> next imem_addr=0x0FC; with branch_imm=16'h0003 -> 0x110.
REQ-033 stall=1 for 5 ISSUE cycles -> instr, pc_plus4 and instr_valid=1 unchanged, imem_req=0, then a single PC advance.
REQ-034 RESET_PC=32'hFFFF_FFFC, no branch -> second fetch address 32'h0000_0000.
REQ-035 With IFETCH_TIMEOUT_EN and imem_ack=0 for 16 cycles -> fetch_err=1 and imem_req=0 thereafter; an ack at cycle 15 -> no error.
REQ-036 rst_n pulsed low during ISSUE -> instr_valid=0 immediately (asynchronous), then refetch from RESET_PC.
